// File: rtl/cdc_pulse_data_tx.sv
// -----------------------------------------------------------------------------
// cdc_pulse_data_tx
//
// Source side of a multi-channel pulse-to-handshake clock domain crossing.
// Each channel delivers single-cycle valid pulses with data. Each pulse is held
// in a per-channel pending register. A round-robin arbiter moves one pending
// word per cycle into a small FIFO. A four-phase req/ack handshake then sends
// the FIFO contents, one word at a time, to an asynchronous destination.
//
// Ports
//   s_clk      : sole clock, rising edge
//   s_rstn     : asynchronous active-low reset
//   s_din      : CH*DW channel data, channel i at [i*DW +: DW]
//   s_vld      : per-channel single-cycle valid pulse
//   s_rdy      : channel i may pulse s_vld (its pending register is free)
//   s_drop     : registered one-cycle pulse, pulse on channel i was discarded
//   async_dat  : data towards the destination, stable while the handshake runs
//   async_ch   : channel tag of async_dat
//   async_req  : four-phase request level
//   async_ack  : four-phase acknowledge, asynchronous to s_clk
//   active     : something is pending, queued or in flight
// -----------------------------------------------------------------------------
module cdc_pulse_data_tx #(
    parameter  int DW    = 8,
    parameter  int CH    = 4,
    parameter  int DEPTH = 4,
    parameter  int SYNC  = 2,
    localparam int CW    = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              s_clk,
    input  logic              s_rstn,
    input  logic [CH*DW-1:0]  s_din,
    input  logic [CH-1:0]     s_vld,
    output logic [CH-1:0]     s_rdy,
    output logic [CH-1:0]     s_drop,
    output logic [DW-1:0]     async_dat,
    output logic [CW-1:0]     async_ch,
    output logic              async_req,
    input  logic              async_ack,
    output logic              active
);

    localparam int AW = $clog2(DEPTH);
    localparam int FW = CW + DW;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_REQ      = 2'd1,
        ST_WAIT_LOW = 2'd2
    } state_t;

    logic [CH-1:0]   pend;
    logic [DW-1:0]   pend_dat [CH];
    logic [CH-1:0]   drop_q;
    logic [CW-1:0]   rr_last;
    logic [CW-1:0]   gnt_idx;
    logic [CW-1:0]   cand;
    logic            gnt_vld;
    logic [FW-1:0]   fifo_mem [DEPTH];
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;
    logic            fifo_full;
    logic            fifo_empty;
    logic [SYNC-1:0] ack_sync;
    logic            ack_s;
    state_t          state_q;
    state_t          state_d;
    logic            pop;

    // Channel index k positions after base, wrapping at CH.
    function automatic logic [CW-1:0] rr_next(input logic [CW-1:0] base, input int k);
        int s;
        s = (int'(base) + k) % CH;
        return CW'(s);
    endfunction

    // ---- capture stage: per-channel pending registers ----
    always_ff @(posedge s_clk or negedge s_rstn) begin
        if (!s_rstn) begin
            pend   <= '0;
            drop_q <= '0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                if (s_vld[i] && !pend[i]) begin
                    pend[i] <= 1'b1;
                end else if (gnt_vld && gnt_idx == CW'(i)) begin
                    pend[i] <= 1'b0;
                end
            end
            // A pulse that meets a still-pending register is lost.
            drop_q <= s_vld & pend;
        end
    end

    always_ff @(posedge s_clk) begin
        for (int i = 0; i < CH; i++) begin
            if (s_vld[i] && !pend[i]) begin
                pend_dat[i] <= s_din[i*DW +: DW];
            end
        end
    end

    assign s_rdy  = ~pend;
    assign s_drop = drop_q;

    // ---- arbitration stage: round-robin grant into the FIFO ----
    // The search starts one past the last granted channel. A full FIFO
    // suppresses the grant, so the pending registers simply hold.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = rr_last;
        cand    = '0;
        for (int k = 1; k <= CH; k++) begin
            cand = rr_next(rr_last, k);
            if (!gnt_vld && pend[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
        if (fifo_full) begin
            gnt_vld = 1'b0;
        end
    end

    always_ff @(posedge s_clk or negedge s_rstn) begin
        if (!s_rstn) begin
            rr_last <= CW'(CH - 1);
        end else if (gnt_vld) begin
            rr_last <= gnt_idx;
        end
    end

    // ---- queue stage: FIFO of {channel, data} ----
    // The pointers carry one extra wrap bit. Equal pointers mean empty.
    // Equal indices with opposite wrap bits mean full.
    always_ff @(posedge s_clk) begin
        if (gnt_vld) begin
            fifo_mem[wptr[AW-1:0]] <= {gnt_idx, pend_dat[gnt_idx]};
        end
    end

    always_ff @(posedge s_clk or negedge s_rstn) begin
        if (!s_rstn) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (gnt_vld) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
        end
    end

    assign fifo_empty = (wptr == rptr);
    assign fifo_full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // ---- handshake stage: ack synchroniser and four-phase FSM ----
    always_ff @(posedge s_clk or negedge s_rstn) begin
        if (!s_rstn) begin
            ack_sync <= '0;
        end else begin
            ack_sync <= {ack_sync[SYNC-2:0], async_ack};
        end
    end

    assign ack_s = ack_sync[SYNC-1];

    always_ff @(posedge s_clk or negedge s_rstn) begin
        if (!s_rstn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (ack_s) state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW: begin
                if (!ack_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Data and tag load only on a pop. They therefore stay frozen through
    // the whole REQ / WAIT_LOW exchange.
    always_ff @(posedge s_clk or negedge s_rstn) begin
        if (!s_rstn) begin
            async_req <= 1'b0;
            async_dat <= '0;
            async_ch  <= '0;
        end else begin
            async_req <= (state_d == ST_REQ);
            if (pop) begin
                {async_ch, async_dat} <= fifo_mem[rptr[AW-1:0]];
            end
        end
    end

    assign active = (|pend) | !fifo_empty | (state_q != ST_IDLE) | ack_s;

endmodule

// File: tb/tb_cdc_pulse_data_tx.sv
module tb_cdc_pulse_data_tx;

    localparam int DW    = 8;
    localparam int CH    = 4;
    localparam int DEPTH = 4;
    localparam int SYNC  = 2;
    localparam int CW    = 2;

    logic             s_clk = 1'b0;
    logic             s_rstn;
    logic [CH*DW-1:0] s_din;
    logic [CH-1:0]    s_vld;
    logic [CH-1:0]    s_rdy;
    logic [CH-1:0]    s_drop;
    logic [DW-1:0]    async_dat;
    logic [CW-1:0]    async_ch;
    logic             async_req;
    logic             async_ack = 1'b0;
    logic             active;

    cdc_pulse_data_tx #(.DW(DW), .CH(CH), .DEPTH(DEPTH), .SYNC(SYNC)) dut (
        .s_clk     (s_clk),
        .s_rstn    (s_rstn),
        .s_din     (s_din),
        .s_vld     (s_vld),
        .s_rdy     (s_rdy),
        .s_drop    (s_drop),
        .async_dat (async_dat),
        .async_ch  (async_ch),
        .async_req (async_req),
        .async_ack (async_ack),
        .active    (active)
    );

    always #5 s_clk = ~s_clk;

    int               n_assert = 0;
    int               n_fail   = 0;
    logic             ack_hold = 1'b0;
    logic [2:0]       ack_dly  = '0;
    logic [CW+DW-1:0] rx_q [$];
    logic [CH-1:0]    drop_seen = '0;
    logic             in_xfer   = 1'b0;
    logic [CW+DW-1:0] held      = '0;
    int               cnt  [CH];
    int               seen [CH];
    logic [CW+DW-1:0] ent;
    int               chn;
    int               nwait;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Destination model: ack follows req three cycles later. It is forced
    // low while ack_hold is set, and it is reset together with the DUT.
    always @(negedge s_clk) begin
        if (!s_rstn) begin
            ack_dly   = '0;
            async_ack = 1'b0;
        end else begin
            ack_dly   = {ack_dly[1:0], async_req};
            async_ack = ack_hold ? 1'b0 : ack_dly[2];
        end
    end

    // Record each transfer at req rise. Data and tag must then hold until
    // both req and ack are low again.
    always @(negedge s_clk) begin
        if (!s_rstn) begin
            in_xfer = 1'b0;
        end else begin
            drop_seen = drop_seen | s_drop;
            if (in_xfer) begin
                check("stable", 32'({async_ch, async_dat}), 32'(held));
                if (!async_req && !async_ack) in_xfer = 1'b0;
            end else if (async_req) begin
                held = {async_ch, async_dat};
                rx_q.push_back(held);
                in_xfer = 1'b1;
            end
        end
    end

    function automatic logic [31:0] rx_at(input int k);
        if (k < rx_q.size()) return 32'(rx_q[k]);
        return {32{1'bx}};
    endfunction

    task automatic step();
        @(posedge s_clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        s_rstn   = 1'b0;
        s_vld    = '0;
        s_din    = '0;
        ack_hold = 1'b0;
        steps(2);
        s_rstn = 1'b1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (active && n < 500) begin
            step();
            n++;
        end
        check(tag, 32'(active), 32'd0);
    endtask

    task automatic drive_pulses();
        s_vld = '0;
        for (int c = 0; c < CH; c++) begin
            if (s_rdy[c] && cnt[c] < 4) begin
                s_vld[c]          = 1'b1;
                s_din[c*DW +: DW] = 8'(c * 16 + cnt[c]);
                cnt[c]++;
            end
        end
    endtask

    function automatic int issued();
        int s;
        s = 0;
        for (int c = 0; c < CH; c++) s += cnt[c];
        return s;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s_rstn = 1'b0;
        s_vld  = '0;
        s_din  = '0;
        steps(3);
        check("rst_rdy",    32'(s_rdy),     32'hF);
        check("rst_drop",   32'(s_drop),    32'h0);
        check("rst_req",    32'(async_req), 32'h0);
        check("rst_dat",    32'(async_dat), 32'h0);
        check("rst_ch",     32'(async_ch),  32'h0);
        check("rst_active", 32'(active),    32'h0);
        s_rstn = 1'b1;
        steps(2);

        // Single transfer on channel 2, latency and handshake timing
        rx_q.delete();
        drop_seen = '0;
        s_din = 32'h00A5_0000;
        s_vld = 4'b0100;
        step();                                    // edge n+1: pending
        s_vld = '0;
        s_din = '0;
        check("t1_rdy_pend", 32'(s_rdy),     32'hB);
        check("t1_active",   32'(active),    32'h1);
        check("t1_req_n1",   32'(async_req), 32'h0);
        step();                                    // edge n+2: FIFO write
        check("t1_rdy_back", 32'(s_rdy),     32'hF);
        check("t1_req_n2",   32'(async_req), 32'h0);
        step();                                    // edge n+3: req rises
        check("t1_req_n3",   32'(async_req), 32'h1);
        check("t1_dat",      32'(async_dat), 32'hA5);
        check("t1_ch",       32'(async_ch),  32'h2);
        steps(4);
        check("t1_req_hold", 32'(async_req), 32'h1);
        step();
        check("t1_req_fall", 32'(async_req), 32'h0);
        wait_idle("t1_idle");
        check("t1_rx_n",  32'(rx_q.size()), 32'd1);
        check("t1_rx0",   rx_at(0), 32'h2A5);
        check("t1_drops", 32'(drop_seen), 32'h0);

        // All four channels in one cycle leave in channel order
        do_reset();
        rx_q.delete();
        drop_seen = '0;
        s_din = 32'h1312_1110;
        s_vld = 4'hF;
        step();
        s_vld = '0;
        check("t2_rdy_all_pend", 32'(s_rdy), 32'h0);
        wait_idle("t2_idle");
        check("t2_rx_n", 32'(rx_q.size()), 32'd4);
        check("t2_rx0",  rx_at(0), 32'h010);
        check("t2_rx1",  rx_at(1), 32'h111);
        check("t2_rx2",  rx_at(2), 32'h212);
        check("t2_rx3",  rx_at(3), 32'h313);
        check("t2_drops", 32'(drop_seen), 32'h0);

        // Back-to-back pulses on channel 1: second is dropped
        rx_q.delete();
        drop_seen = '0;
        s_din = 32'h0000_0100;
        s_vld = 4'b0010;
        step();
        s_din = 32'h0000_0200;
        s_vld = 4'b0010;
        check("t3_rdy_busy", 32'(s_rdy), 32'hD);
        step();
        s_vld = '0;
        check("t3_drop_on",  32'(s_drop), 32'h2);
        check("t3_rdy_back", 32'(s_rdy),  32'hF);
        step();
        check("t3_drop_off", 32'(s_drop), 32'h0);
        wait_idle("t3_idle");
        check("t3_rx_n",     32'(rx_q.size()), 32'd1);
        check("t3_rx0",      rx_at(0), 32'h101);
        check("t3_drops",    32'(drop_seen), 32'h2);

        // Back-pressure: ack held low fills the FIFO and pending registers
        do_reset();
        rx_q.delete();
        drop_seen = '0;
        ack_hold  = 1'b1;
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        for (int i = 0; i < 20; i++) begin
            drive_pulses();
            step();
        end
        s_vld = '0;
        check("t4_rdy_full", 32'(s_rdy),     32'h0);
        check("t4_req_held", 32'(async_req), 32'h1);
        check("t4_ch_held",  32'(async_ch),  32'h0);
        check("t4_dat_held", 32'(async_dat), 32'h00);
        check("t4_active",   32'(active),    32'h1);
        check("t4_issued9",  32'(issued()),  32'd9);
        // Pulses against full pending registers must not alter stored data
        s_din = 32'hEEEE_EEEE;
        s_vld = 4'hF;
        step();
        s_vld = '0;
        check("t4_drop_all", 32'(s_drop), 32'hF);
        step();
        check("t4_drop_off", 32'(s_drop), 32'h0);
        ack_hold = 1'b0;
        nwait = 0;
        while (issued() < 16 && nwait < 600) begin
            drive_pulses();
            step();
            nwait++;
        end
        s_vld = '0;
        check("t4_issued16", 32'(issued()), 32'd16);
        wait_idle("t4_idle");
        check("t4_rx_n", 32'(rx_q.size()), 32'd16);
        check("t4_rx0",  rx_at(0), 32'h000);
        check("t4_rx1",  rx_at(1), 32'h110);
        check("t4_rx2",  rx_at(2), 32'h220);
        check("t4_rx3",  rx_at(3), 32'h330);
        check("t4_rx4",  rx_at(4), 32'h001);
        check("t4_rx5",  rx_at(5), 32'h111);
        check("t4_rx6",  rx_at(6), 32'h221);
        check("t4_rx7",  rx_at(7), 32'h331);
        check("t4_rx8",  rx_at(8), 32'h002);
        for (int c = 0; c < CH; c++) seen[c] = 0;
        for (int k = 0; k < rx_q.size(); k++) begin
            ent = rx_q[k];
            chn = int'(ent[9:8]);
            check("t4_chan_order", 32'(ent[7:0]), 32'(chn * 16 + seen[chn]));
            seen[chn]++;
        end
        check("t4_drops", 32'(drop_seen), 32'hF);

        // Reset in the middle of a handshake, then a clean transfer
        rx_q.delete();
        drop_seen = '0;
        s_din = 32'h7700_0000;
        s_vld = 4'b1000;
        step();
        s_vld = '0;
        nwait = 0;
        while (!async_req && nwait < 10) begin
            step();
            nwait++;
        end
        check("t5_req_up", 32'(async_req), 32'h1);
        s_rstn = 1'b0;
        #1;
        check("t5_rst_req",    32'(async_req), 32'h0);
        check("t5_rst_active", 32'(active),    32'h0);
        check("t5_rst_rdy",    32'(s_rdy),     32'hF);
        check("t5_rst_dat",    32'(async_dat), 32'h0);
        check("t5_rst_ch",     32'(async_ch),  32'h0);
        steps(2);
        s_rstn = 1'b1;
        rx_q.delete();
        drop_seen = '0;
        s_din = 32'h0000_003C;
        s_vld = 4'b0001;
        step();
        s_vld = '0;
        wait_idle("t5_idle");
        check("t5_rx_n",  32'(rx_q.size()), 32'd1);
        check("t5_rx0",   rx_at(0), 32'h03C);
        check("t5_drops", 32'(drop_seen), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
